// File: rtl/snn_pkg.sv
// Shared definitions for the SNN timestep scheduler and the parameter BRAM driver.
package snn_pkg;

  // Driver mode codes, shared with the BRAM driver
  localparam logic [4:0] CORE_READ_PARAMS  = 5'd0;
  localparam logic [4:0] CORE_WRITE_PARAMS = 5'd1;
  localparam logic [4:0] LIF_READ_INPUT    = 5'd2;
  localparam logic [4:0] LIF_WRITE_SPIKES  = 5'd3;

  typedef enum logic [2:0] {
    IDLE, C_RD, C_EXEC, C_WR, L_RD, L_EXEC, L_WR, FINISH
  } sched_state_t;

  // Sub-steps of a single driver operation
  typedef enum logic [1:0] {
    OP_IDLE, OP_WAIT, OP_GAP
  } op_state_t;

endpackage

// File: rtl/drv_op_seq.sv
// One BRAM driver operation: raise enable, hold it until drv_done, then a
// one-cycle gap with enable low so the driver can clear its done flag.
// A watchdog bounds the wait; op_done/op_timeout are one-cycle pulses.
module drv_op_seq #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic abort,
  input  logic drv_done,
  output logic drv_enable,
  output logic op_done,
  output logic op_timeout
);
  import snn_pkg::*;

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  op_state_t     st;
  logic [WW-1:0] wd;

  // Issue/wait/gap handshake with per-op watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= OP_IDLE;
      drv_enable <= 1'b0;
      op_done    <= 1'b0;
      op_timeout <= 1'b0;
      wd         <= '0;
    end else begin
      op_done    <= 1'b0;
      op_timeout <= 1'b0;
      if (abort) begin
        st         <= OP_IDLE;
        drv_enable <= 1'b0;
      end else begin
        case (st)
          OP_IDLE: if (go) begin
            st         <= OP_WAIT;
            drv_enable <= 1'b1;
            wd         <= '0;
          end
          OP_WAIT: begin
            if (drv_done) begin
              // op_done is high during the gap cycle itself
              st         <= OP_GAP;
              drv_enable <= 1'b0;
              op_done    <= 1'b1;
            end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
              st         <= OP_IDLE;
              drv_enable <= 1'b0;
              op_timeout <= 1'b1;
            end else begin
              wd <= wd + WW'(1);
            end
          end
          OP_GAP:  st <= OP_IDLE;
          default: st <= OP_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Sequences one SNN timestep: every synapse tile is read, computed and
// written back, then every LIF tile is read, integrated and written back.
// Owns the BRAM driver's mode/index/enable and the core start pulses.
module snn_timestep_scheduler #(
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int MAX_TILES       = 16,
  parameter int MAX_LIF_TILES   = 4,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int TS_WIDTH        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [$clog2(MAX_TILES):0]     num_core_tiles,
  input  logic [$clog2(MAX_LIF_TILES):0] num_lif_tiles,
  output logic [4:0]                    drv_mode,
  output logic                          drv_enable,
  input  logic                          drv_done,
  output logic [BRAM_DATA_WIDTH-1:0]    core_idx,
  output logic [BRAM_DATA_WIDTH-1:0]    lif_tile_idx,
  output logic                          core_start,
  input  logic                          core_done,
  output logic                          lif_start,
  input  logic                          lif_done,
  output logic                          busy,
  output logic                          ts_done,
  output logic [TS_WIDTH-1:0]           timestep,
  output logic                          error
);
  import snn_pkg::*;

  localparam int CW = $clog2(MAX_TILES) + 1;
  localparam int LW = $clog2(MAX_LIF_TILES) + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t  state;
  logic [CW-1:0] cidx, nc, nc_clamp;
  logic [LW-1:0] lidx, nl, nl_clamp;
  logic [WW-1:0] exec_wd;
  logic          go, op_done, op_timeout;

  assign nc_clamp = (num_core_tiles > CW'(MAX_TILES))    ? CW'(MAX_TILES)    : num_core_tiles;
  assign nl_clamp = (num_lif_tiles  > LW'(MAX_LIF_TILES)) ? LW'(MAX_LIF_TILES) : num_lif_tiles;

  assign core_idx     = BRAM_DATA_WIDTH'(cidx);
  assign lif_tile_idx = BRAM_DATA_WIDTH'(lidx);

  drv_op_seq #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_op (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .abort      (abort),
    .drv_done   (drv_done),
    .drv_enable (drv_enable),
    .op_done    (op_done),
    .op_timeout (op_timeout)
  );

  // Timestep FSM; mode/index change one cycle ahead of the op's enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      drv_mode   <= CORE_READ_PARAMS;
      go         <= 1'b0;
      cidx       <= '0;
      lidx       <= '0;
      nc         <= '0;
      nl         <= '0;
      exec_wd    <= '0;
      core_start <= 1'b0;
      lif_start  <= 1'b0;
      ts_done    <= 1'b0;
      timestep   <= '0;
      error      <= 1'b0;
    end else begin
      go         <= 1'b0;
      core_start <= 1'b0;
      lif_start  <= 1'b0;
      ts_done    <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            error <= 1'b0;
            cidx  <= '0;
            lidx  <= '0;
            nc    <= nc_clamp;
            nl    <= nl_clamp;
            busy  <= 1'b1;
            if (nc_clamp != '0) begin
              state    <= C_RD;
              drv_mode <= CORE_READ_PARAMS;
              go       <= 1'b1;
            end else if (nl_clamp != '0) begin
              state    <= L_RD;
              drv_mode <= LIF_READ_INPUT;
              go       <= 1'b1;
            end else begin
              state <= FINISH;
            end
          end
          C_RD, L_RD: begin
            if (op_timeout) begin
              state <= IDLE;
              busy  <= 1'b0;
              error <= 1'b1;
            end else if (op_done) begin
              exec_wd <= '0;
              if (state == C_RD) begin
                state      <= C_EXEC;
                core_start <= 1'b1;
              end else begin
                state     <= L_EXEC;
                lif_start <= 1'b1;
              end
            end
          end
          C_EXEC, L_EXEC: begin
            if ((state == C_EXEC) ? core_done : lif_done) begin
              state    <= (state == C_EXEC) ? C_WR : L_WR;
              drv_mode <= (state == C_EXEC) ? CORE_WRITE_PARAMS : LIF_WRITE_SPIKES;
              go       <= 1'b1;
            end else if (exec_wd == WW'(TIMEOUT_CYCLES - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              exec_wd <= exec_wd + WW'(1);
            end
          end
          C_WR: begin
            if (op_timeout) begin
              state <= IDLE;
              busy  <= 1'b0;
              error <= 1'b1;
            end else if (op_done) begin
              cidx <= cidx + CW'(1);
              if (cidx + CW'(1) != nc) begin
                state    <= C_RD;
                drv_mode <= CORE_READ_PARAMS;
                go       <= 1'b1;
              end else if (nl != '0) begin
                state    <= L_RD;
                drv_mode <= LIF_READ_INPUT;
                go       <= 1'b1;
              end else begin
                state <= FINISH;
              end
            end
          end
          L_WR: begin
            if (op_timeout) begin
              state <= IDLE;
              busy  <= 1'b0;
              error <= 1'b1;
            end else if (op_done) begin
              lidx <= lidx + LW'(1);
              if (lidx + LW'(1) != nl) begin
                state    <= L_RD;
                drv_mode <= LIF_READ_INPUT;
                go       <= 1'b1;
              end else begin
                state <= FINISH;
              end
            end
          end
          FINISH: begin
            ts_done  <= 1'b1;
            timestep <= timestep + TS_WIDTH'(1);
            state    <= IDLE;
            busy     <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
